// File: rtl/gb_alu_pkg.sv
// Shared types for the 16-bit sequencer and the 8-bit ALU it drives:
// ALU opcodes, sequencer operation codes and sequencer states.
package gb_alu_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_RL  = 4'b1010;

    typedef enum logic [1:0] {
        SEQ_ADD16 = 2'b00,
        SEQ_XOR16 = 2'b01,
        SEQ_RL16  = 2'b10,
        SEQ_RSVD  = 2'b11
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu16_seq_if.sv
// Request/response bundle of the 16-bit sequencer: operation request in,
// status pulses and held result/flags out.
interface alu16_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic        zf_in;
    logic        cf_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] r;
    logic        zf_out;
    logic        nf_out;
    logic        hf_out;
    logic        cf_out;

    modport master (
        output start, op, lhs, rhs, zf_in, cf_in,
        input  busy, done, err, r, zf_out, nf_out, hf_out, cf_out
    );

    modport slave (
        input  start, op, lhs, rhs, zf_in, cf_in,
        output busy, done, err, r, zf_out, nf_out, hf_out, cf_out
    );

endinterface

// File: rtl/alu16_seq.sv
// 16-bit ADD/XOR/RL sequencer that runs each operation as two byte passes
// through an external, shareable 8-bit ALU (low byte first, then high byte).
module alu16_seq
    import gb_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu16_seq_if.slave  bus,
    output logic [7:0]  alu_lhs,
    output logic [7:0]  alu_rhs,
    output logic [3:0]  alu_op,
    output logic        alu_zf,
    output logic        alu_nf,
    output logic        alu_hf,
    output logic        alu_cf,
    input  logic [7:0]  alu_r,
    input  logic        alu_zf_o,
    input  logic        alu_nf_o,
    input  logic        alu_hf_o,
    input  logic        alu_cf_o
);

    state_e      state_q, state_d;
    seq_op_e     op_q;
    logic [15:0] lhs_q, rhs_q;
    logic        zf_q, cf_q;
    logic        carry_q;
    logic [15:0] r_q;
    logic        zf_out_q, hf_out_q, cf_out_q;
    logic        err_q;
    logic        accept, rsvd;
    logic        hi_sel;
    logic        res_zero;

    // The sequencer computes its own zero/negative flags, so the ALU's are not consumed.
    logic        unused_alu_flags;
    assign unused_alu_flags = alu_zf_o ^ alu_nf_o;

    assign hi_sel   = (state_q == ST_HI);
    assign res_zero = (alu_r == 8'h00) && (r_q[7:0] == 8'h00);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rsvd    = 1'b0;
        alu_op  = ALU_NOP;
        alu_lhs = 8'h00;
        alu_rhs = 8'h00;
        alu_zf  = 1'b0;
        alu_nf  = 1'b0;
        alu_hf  = 1'b0;
        alu_cf  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == SEQ_RSVD) begin
                        rsvd = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO, ST_HI: begin
                state_d = hi_sel ? ST_DONE : ST_HI;
                case (op_q)
                    SEQ_ADD16: begin
                        alu_op  = hi_sel ? ALU_ADC : ALU_ADD;
                        alu_lhs = hi_sel ? lhs_q[15:8] : lhs_q[7:0];
                        alu_rhs = hi_sel ? rhs_q[15:8] : rhs_q[7:0];
                        alu_cf  = hi_sel ? carry_q : 1'b0;
                    end
                    SEQ_XOR16: begin
                        alu_op  = ALU_XOR;
                        alu_lhs = hi_sel ? lhs_q[15:8] : lhs_q[7:0];
                        alu_rhs = hi_sel ? rhs_q[15:8] : rhs_q[7:0];
                    end
                    SEQ_RL16: begin
                        // Rotate-through-carry chains bit 7 of the low byte into bit 8.
                        alu_op  = ALU_RL;
                        alu_rhs = hi_sel ? rhs_q[15:8] : rhs_q[7:0];
                        alu_cf  = hi_sel ? carry_q : cf_q;
                    end
                    default: ;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r_q      <= 16'h0000;
            zf_out_q <= 1'b0;
            hf_out_q <= 1'b0;
            cf_out_q <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= rsvd;
            if (state_q == ST_LO) begin
                r_q[7:0] <= alu_r;
                carry_q  <= alu_cf_o;
            end
            if (state_q == ST_HI) begin
                r_q[15:8] <= alu_r;
                case (op_q)
                    SEQ_ADD16: begin
                        zf_out_q <= zf_q;
                        hf_out_q <= alu_hf_o;
                        cf_out_q <= alu_cf_o;
                    end
                    SEQ_RL16: begin
                        zf_out_q <= res_zero;
                        hf_out_q <= 1'b0;
                        cf_out_q <= rhs_q[15];
                    end
                    default: begin
                        zf_out_q <= res_zero;
                        hf_out_q <= 1'b0;
                        cf_out_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Operand capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= seq_op_e'(bus.op);
            lhs_q <= bus.lhs;
            rhs_q <= bus.rhs;
            zf_q  <= bus.zf_in;
            cf_q  <= bus.cf_in;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.r      = r_q;
    assign bus.zf_out = zf_out_q;
    assign bus.nf_out = 1'b0;
    assign bus.hf_out = hf_out_q;
    assign bus.cf_out = cf_out_q;

endmodule

// File: doc/alu16_seq.md
ALU16_SEQ -- requirements
Module: alu16_seq

Interface
REQ-001 The block SHALL provide port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL provide port start, input, 1, request a 16-bit operation; sampled only in IDLE.
REQ-004 The block SHALL provide port op, input, 2, operation code: 00 ADD16, 01 XOR16, 10 RL16, 11 reserved.
REQ-005 The block SHALL provide ports lhs and rhs, input, 16 each, operands captured on the accepting edge.
REQ-006 The block SHALL provide ports zf_in and cf_in, input, 1 each, caller flags captured on the accepting edge.
REQ-007 The block SHALL provide port busy, output, 1, high whenever state is not IDLE.
REQ-008 The block SHALL provide port done, output, 1, one-cycle completion pulse.
REQ-009 The block SHALL provide port err, output, 1, one-cycle pulse on a reserved op.
REQ-010 The block SHALL provide port r, output, 16, result, held from done until the next accepted start.
REQ-011 The block SHALL provide ports zf_out, nf_out, hf_out and cf_out, output, 1 each, result flags, held like r.
REQ-012 The block SHALL provide ALU-facing outputs alu_lhs and alu_rhs (8 each), alu_op (4), and alu_zf, alu_nf, alu_hf, alu_cf (1 each).
REQ-013 The block SHALL provide ALU-facing inputs alu_r (8) and alu_zf_o, alu_nf_o, alu_hf_o, alu_cf_o (1 each).

Function
REQ-014 The block SHALL implement the states IDLE, LO, HI and DONE.
REQ-015 In IDLE, start=1 with op!=11 SHALL capture operands and flags and move to LO.
REQ-016 In IDLE, start=1 with op=11 SHALL pulse err for one cycle, leave r and the flags unchanged, issue no ALU op, and stay in IDLE.
REQ-017 LO SHALL drive the low bytes to the ALU, register alu_r into r[7:0] and register alu_cf_o as the internal carry, then move to HI.
REQ-018 HI SHALL drive the high bytes with alu_cf equal to the internal carry, register alu_r into r[15:8] and register the flags, then move to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle and then move to IDLE, so done is high on the third cycle after the accepting edge.
REQ-020 ADD16 SHALL use ALU ADD (0000) in LO and ALU ADC (0001) in HI.
REQ-021 ADD16 flags SHALL be: z = captured zf_in, n = 0, h = HI alu_hf_o (carry from bit 11), c = HI alu_cf_o.
REQ-022 XOR16 SHALL use ALU XOR (0101) in both LO and HI.
REQ-023 XOR16 flags SHALL be: z = (r == 0), n = 0, h = 0, c = 0.
REQ-024 RL16 SHALL use ALU RL (1010) with the operand on alu_rhs.
REQ-025 For RL16, LO carry-in SHALL be the captured cf_in and HI carry-in SHALL be the LO carry-out.
REQ-026 RL16 flags SHALL be: z = (r == 0), n = 0, h = 0, c = original bit 15.
REQ-027 Outside LO and HI, the ALU-facing outputs SHALL be alu_op=0000 with all data and flag lines 0.
REQ-028 start while busy SHALL be ignored, with no queuing.
REQ-029 start asserted in the same cycle as done SHALL be ignored; a new operation is accepted only in IDLE.
REQ-030 Sum arithmetic SHALL wrap modulo 2^16, and the carry SHALL be reported only in cf_out.

Reset
REQ-031 rst SHALL force IDLE immediately, asynchronously.
REQ-032 rst SHALL clear r, all result flags, busy, done, err and the internal carry to 0.
REQ-033 rst asserted during LO or HI SHALL abort the operation without a done pulse.
REQ-034 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-035 A shared package gb_alu_pkg SHALL hold the 4-bit ALU opcode constants, the 2-bit sequencer op enum and the state enum.
REQ-036 The block SHALL contain no sub-module; the 8-bit ALU SHALL be instantiated by the parent so it can be shared.

Verification
REQ-037 ADD16 0x0FFF+0x0001 with zf_in=1 -> r=0x1000, z=1, n=0, h=1, c=0, and done 3 cycles after accept.
REQ-038 ADD16 0xFFFF+0x0001 with zf_in=0 -> r=0x0000, z=0, h=1, c=1.
REQ-039 XOR16 0x1234^0x1234 -> r=0x0000, z=1, n=0, h=0, c=0; then 0x00FF^0x0F0F -> r=0x0FF0, z=0.
REQ-040 RL16 rhs=0x8001 with cf_in=1 -> r=0x0003, c=1, z=0; rhs=0x8000 with cf_in=0 -> r=0x0000, c=1, z=1.
REQ-041 start pulsed in LO, HI and DONE -> ignored, exactly one done; op=11 -> single err pulse, busy stays 0.
REQ-042 rst asserted in HI -> all outputs 0 immediately, no done; a following ADD16 0x0001+0x0001 -> r=0x0002.
